// File: rtl/frame_latch.sv
// Double-buffered game-board latch: producer fills a back buffer column by column,
// and the renderer sees a front buffer that only changes at vblank after a commit.

package game_state_pkg;
  localparam int BOARD_COLS = 10;
  localparam int BOARD_ROWS = 20;

  typedef struct packed {
    logic [BOARD_COLS-1:0][BOARD_ROWS-1:0] screen;
  } game_state_t;
endpackage

// One board column: back-buffer word plus its front-buffer copy.
module frame_latch_col #(
  parameter int BOARD_ROWS = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [BOARD_ROWS-1:0] wr_data_i,
  input  logic                  swap_i,
  output logic [BOARD_ROWS-1:0] front_o
);
  logic [BOARD_ROWS-1:0] back_q, back_d;
  logic [BOARD_ROWS-1:0] front_q, front_d;

  always_comb begin
    back_d  = back_q;
    front_d = front_q;
    if (wr_en_i) back_d  = wr_data_i;
    if (swap_i)  front_d = back_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      back_q  <= '0;
      front_q <= '0;
    end else begin
      back_q  <= back_d;
      front_q <= front_d;
    end
  end

  assign front_o = front_q;
endmodule

module frame_latch #(
  parameter int BOARD_COLS       = game_state_pkg::BOARD_COLS,
  parameter int BOARD_ROWS       = game_state_pkg::BOARD_ROWS,
  parameter int COL_BITS         = $clog2(BOARD_COLS),
  parameter int SWAP_COUNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               vblank_start,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [COL_BITS-1:0]                wr_col,
  input  logic [BOARD_ROWS-1:0]              wr_data,
  input  logic                               wr_last,
  output game_state_pkg::game_state_t        frame,
  output logic                               frame_pending,
  output logic                               frame_swapped,
  output logic [SWAP_COUNT_WIDTH-1:0]        swap_count,
  output logic                               col_err
);
  localparam logic [0:0] ST_LOAD    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(BOARD_COLS - 1);

  logic [0:0]                  state_q, state_d;
  logic                        swapped_q, swapped_d;
  logic [SWAP_COUNT_WIDTH-1:0] count_q, count_d;
  logic                        err_q, err_d;

  logic accept, col_ok, swap;
  logic [BOARD_COLS-1:0][BOARD_ROWS-1:0] front;

  // Handshake depends only on state, so wr_ready has no path from wr_valid.
  assign accept = wr_valid && (state_q == ST_LOAD);
  assign col_ok = (wr_col <= LAST_COL);
  assign swap   = (state_q == ST_PENDING) && vblank_start;

  genvar c;
  generate
    for (c = 0; c < BOARD_COLS; c++) begin : g_col
      frame_latch_col #(.BOARD_ROWS(BOARD_ROWS)) u_col (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (accept && (wr_col == COL_BITS'(c))),
        .wr_data_i (wr_data),
        .swap_i    (swap),
        .front_o   (front[c])
      );
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    swapped_d = swap;
    count_d   = count_q;
    err_d     = err_q;
    if (accept && !col_ok) err_d = 1'b1;
    // Commit wins over a coincident vblank: that frame is skipped, not torn.
    if (accept && wr_last) state_d = ST_PENDING;
    if (swap) begin
      state_d = ST_LOAD;
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      swapped_q <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      swapped_q <= swapped_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign frame.screen  = front;
  assign wr_ready      = (state_q == ST_LOAD);
  assign frame_pending = (state_q == ST_PENDING);
  assign frame_swapped = swapped_q;
  assign swap_count    = count_q;
  assign col_err       = err_q;
endmodule

// File: tb/tb_frame_latch.sv
// Directed vector bench for frame_latch (swap counter narrowed to 2 bits to hit wrap).

module tb_frame_latch;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int CB   = 4;
  localparam int SCW  = 2;

  logic clk = 1'b0;
  logic reset, vblank_start, wr_valid, wr_last;
  logic wr_ready, frame_pending, frame_swapped, col_err;
  logic [CB-1:0]   wr_col;
  logic [ROWS-1:0] wr_data;
  logic [SCW-1:0]  swap_count;
  game_state_pkg::game_state_t frame;

  int n_vec = 0;
  int n_err = 0;

  frame_latch #(.BOARD_COLS(COLS), .BOARD_ROWS(ROWS), .COL_BITS(CB), .SWAP_COUNT_WIDTH(SCW)) dut (
    .clk           (clk),
    .reset         (reset),
    .vblank_start  (vblank_start),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_col        (wr_col),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .frame         (frame),
    .frame_pending (frame_pending),
    .frame_swapped (frame_swapped),
    .swap_count    (swap_count),
    .col_err       (col_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              vld;
    logic [CB-1:0]   col;
    logic [ROWS-1:0] data;
    bit              last;
    bit              vb;
    bit              e_rdy;
    bit              e_pend;
    bit              e_sw;
    logic [SCW-1:0]  e_cnt;
    bit              e_err;
    int              chk_col;
    logic [ROWS-1:0] e_col;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit vld, int col, int data, bit last, bit vb,
                              bit rdy, bit pend, bit sw, int cnt, bit err,
                              int chk_col, int e_col);
    vec_t v;
    v.vld = vld; v.col = CB'(col); v.data = ROWS'(data); v.last = last; v.vb = vb;
    v.e_rdy = rdy; v.e_pend = pend; v.e_sw = sw; v.e_cnt = SCW'(cnt); v.e_err = err;
    v.chk_col = chk_col; v.e_col = ROWS'(e_col);
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(bit vld, logic [CB-1:0] col, logic [ROWS-1:0] data, bit last, bit vb);
    wr_valid = vld; wr_col = col; wr_data = data; wr_last = last; vblank_start = vb;
  endtask

  task automatic check_outs(string tag, bit rdy, bit pend, bit sw, logic [SCW-1:0] cnt, bit err);
    check({tag, ".wr_ready"},      32'(wr_ready),      32'(rdy));
    check({tag, ".frame_pending"}, 32'(frame_pending), 32'(pend));
    check({tag, ".frame_swapped"}, 32'(frame_swapped), 32'(sw));
    check({tag, ".swap_count"},    32'(swap_count),    32'(cnt));
    check({tag, ".col_err"},       32'(col_err),       32'(err));
  endtask

  initial begin
    // idle(col,val): no beat, check front column
    //                 vld col data     last vb  rdy pend sw cnt err chk  val
    vecs.push_back(mk(1, 0, 'h00001, 0, 0,   1, 0, 0, 0, 0,  0, 'h0));
    vecs.push_back(mk(1, 9, 'h80000, 1, 0,   0, 1, 0, 0, 0,  9, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     0, 0,   0, 1, 0, 0, 0,  0, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     0, 1,   1, 0, 1, 1, 0,  0, 'h1));
    vecs.push_back(mk(0, 0, 'h0,     0, 0,   1, 0, 0, 1, 0,  9, 'h80000));
    // stall: col3 beat held while pending, taken only after the swap
    vecs.push_back(mk(1, 1, 'h00003, 1, 0,   0, 1, 0, 1, 0,  1, 'h0));
    vecs.push_back(mk(1, 3, 'h12345, 0, 0,   0, 1, 0, 1, 0,  3, 'h0));
    vecs.push_back(mk(1, 3, 'h12345, 0, 1,   1, 0, 1, 2, 0,  1, 'h3));
    vecs.push_back(mk(1, 3, 'h12345, 0, 0,   1, 0, 0, 2, 0,  3, 'h0));
    // no commit: vblank in LOAD does nothing
    vecs.push_back(mk(1, 5, 'hFFFFF, 0, 0,   1, 0, 0, 2, 0,  5, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     0, 1,   1, 0, 0, 2, 0,  5, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     0, 1,   1, 0, 0, 2, 0,  3, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     0, 1,   1, 0, 0, 2, 0,  0, 'h1));
    // commit coincident with vblank: swap deferred one vblank
    vecs.push_back(mk(1, 2, 'h0000F, 1, 1,   0, 1, 0, 2, 0,  2, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     0, 0,   0, 1, 0, 2, 0,  5, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     0, 1,   1, 0, 1, 3, 0,  5, 'hFFFFF));
    vecs.push_back(mk(0, 0, 'h0,     0, 0,   1, 0, 0, 3, 0,  2, 'hF));
    vecs.push_back(mk(0, 0, 'h0,     0, 0,   1, 0, 0, 3, 0,  3, 'h12345));
    // bad column commits, sets col_err, 4th swap wraps counter to 0
    vecs.push_back(mk(1, 12, 'hAAAAA, 1, 0,  0, 1, 0, 3, 1,  0, 'h1));
    vecs.push_back(mk(0, 0, 'h0,     0, 1,   1, 0, 1, 0, 1,  0, 'h1));
    vecs.push_back(mk(0, 0, 'h0,     0, 0,   1, 0, 0, 0, 1,  9, 'h80000));
    vecs.push_back(mk(0, 0, 'h0,     0, 0,   1, 0, 0, 0, 1,  1, 'h3));
    vecs.push_back(mk(1, 4, 'h55555, 1, 0,   0, 1, 0, 0, 1,  4, 'h0));
    vecs.push_back(mk(0, 0, 'h0,     0, 1,   1, 0, 1, 1, 1,  4, 'h55555));
    // leave a commit in flight for the reset test
    vecs.push_back(mk(1, 4, 'h00000, 1, 0,   0, 1, 0, 1, 1,  4, 'h55555));

    reset = 1'b1;
    drive(0, '0, '0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_outs("reset", 1, 0, 0, 0, 0);
    check("reset.frame", 32'(frame === '0), 32'd1);

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].col, vecs[i].data, vecs[i].last, vecs[i].vb);
      @(posedge clk);
      #1;
      check_outs($sformatf("v%0d", i), vecs[i].e_rdy, vecs[i].e_pend, vecs[i].e_sw,
                 vecs[i].e_cnt, vecs[i].e_err);
      check($sformatf("v%0d.col%0d", i, vecs[i].chk_col),
            32'(frame.screen[vecs[i].chk_col]), 32'(vecs[i].e_col));
    end

    // async reset mid-cycle while PENDING: outputs clear without a clock edge
    drive(0, '0, '0, 0, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_outs("areset", 1, 0, 0, 0, 0);
    check("areset.frame", 32'(frame === '0), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    // the discarded commit must not swap at the next vblank
    drive(0, '0, '0, 0, 1);
    @(posedge clk);
    #1;
    drive(0, '0, '0, 0, 0);
    check_outs("post_reset_vb", 1, 0, 0, 0, 0);
    check("post_reset_vb.frame", 32'(frame === '0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
